// File: rtl/paddle_pot_reader.sv
// paddle_pot_reader
// Measures an analogue paddle (pot + RC into a threshold comparator) by
// counting video lines. After each vsync the capacitor is held discharged
// for DISCHARGE_LINES lines. The block then counts hsync edges until the
// comparator trips, and turns that count into an 8-bit paddle position.
// A measurement that reaches MAX_LINES is reported as a timeout, which
// usually means the paddle is unplugged or open.
module paddle_pot_reader #(
    parameter int DISCHARGE_LINES = 8,   // 1..63
    parameter int MAX_LINES       = 255, // 1..255
    parameter int INVERT          = 0    // 1: position = 255 - count
) (
    input  logic       clk_sys,
    input  logic       reset,      // asynchronous, active-low
    input  logic       hs,
    input  logic       vs,
    input  logic       pot_in,     // asynchronous comparator output
    output logic       discharge,
    output logic [7:0] position,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DISCHARGE = 2'd1,
        S_MEASURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // The last discharge line and the timeout line, held at line_cnt width
    // so that every compare is the same width.
    localparam logic [8:0] LP_DIS_LAST = 9'(DISCHARGE_LINES - 1);
    localparam logic [8:0] LP_MAX      = 9'(MAX_LINES);

    // Maps a raw line count to a paddle position. The mapping is reversed
    // for pots that are wired the other way round.
    function automatic logic [7:0] f_map_pos(input logic [7:0] cnt);
        if (INVERT != 0) begin
            return 8'd255 - cnt;
        end
        return cnt;
    endfunction

    logic       r_pot_meta;
    logic       r_pot_s;
    logic       r_hs_d;
    logic       r_vs_d;
    state_t     r_state;
    logic       r_discharge;
    logic [7:0] r_position;
    logic       r_valid;
    logic       r_timeout;
    logic [8:0] r_line_cnt;

    logic       w_hs_rise;
    logic       w_vs_rise;
    state_t     w_state_nx;
    logic       w_discharge_nx;
    logic [7:0] w_position_nx;
    logic       w_valid_nx;
    logic       w_timeout_nx;
    logic [8:0] w_line_cnt_nx;

    assign w_hs_rise = hs & ~r_hs_d;
    assign w_vs_rise = vs & ~r_vs_d;

    // Synchronise the comparator and keep one cycle of sync history for edge detection.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_pot_meta <= 1'b0;
            r_pot_s    <= 1'b0;
            r_hs_d     <= 1'b0;
            r_vs_d     <= 1'b0;
        end else begin
            r_pot_meta <= pot_in;
            r_pot_s    <= r_pot_meta;
            r_hs_d     <= hs;
            r_vs_d     <= vs;
        end
    end

    // State, line counter and registered outputs.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_discharge <= 1'b0;
            r_position  <= 8'd128;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_line_cnt  <= 9'd0;
        end else begin
            r_state     <= w_state_nx;
            r_discharge <= w_discharge_nx;
            r_position  <= w_position_nx;
            r_valid     <= w_valid_nx;
            r_timeout   <= w_timeout_nx;
            r_line_cnt  <= w_line_cnt_nx;
        end
    end

    // Next-state logic. vs_rise restarts the frame from any state and masks
    // any hs_rise in the same cycle. IDLE and DONE just wait for vs_rise.
    always_comb begin
        w_state_nx     = r_state;
        w_discharge_nx = r_discharge;
        w_position_nx  = r_position;
        w_valid_nx     = 1'b0;
        w_timeout_nx   = r_timeout;
        w_line_cnt_nx  = r_line_cnt;

        if (w_vs_rise) begin
            w_state_nx     = S_DISCHARGE;
            w_discharge_nx = 1'b1;
            w_line_cnt_nx  = 9'd0;
        end else begin
            case (r_state)
                S_DISCHARGE: begin
                    if (w_hs_rise) begin
                        if (r_line_cnt == LP_DIS_LAST) begin
                            w_state_nx     = S_MEASURE;
                            w_line_cnt_nx  = 9'd0;
                            w_discharge_nx = 1'b0;
                        end else begin
                            w_line_cnt_nx = r_line_cnt + 9'd1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (w_hs_rise) begin
                        if (r_pot_s) begin
                            w_position_nx = f_map_pos(r_line_cnt[7:0]);
                            w_valid_nx    = 1'b1;
                            w_timeout_nx  = 1'b0;
                            w_state_nx    = S_DONE;
                        end else if (r_line_cnt == LP_MAX) begin
                            w_position_nx = f_map_pos(LP_MAX[7:0]);
                            w_valid_nx    = 1'b1;
                            w_timeout_nx  = 1'b1;
                            w_state_nx    = S_DONE;
                        end else begin
                            w_line_cnt_nx = r_line_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign discharge = r_discharge;
    assign position  = r_position;
    assign valid     = r_valid;
    assign timeout   = r_timeout;

endmodule
